// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the write-back stage FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FUNCT_JR = 6'h08;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_LUI);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Big-endian sub-word load alignment with sign/zero extension and misalignment detect.
module wb_load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    return {{(DATA_W-16){h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 is the most significant lane of the word.
  always_comb begin
    byte_sel = rdata[DATA_W-1 - 8*int'(off) -: 8];
    half_sel = off[1] ? rdata[15:0] : rdata[DATA_W-1 -: 16];
  end

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (op)
      OP_LW:  misaligned = (off != 2'd0);
      OP_LH:  begin data = sext16(half_sel);                 misaligned = off[0]; end
      OP_LHU: begin data = {{(DATA_W-16){1'b0}}, half_sel};  misaligned = off[0]; end
      OP_LB:  data = sext8(byte_sel);
      OP_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/estagio_writeback.sv
// Write-back stage: decodes destination, waits for load data, drives the register-file write port.
module estagio_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RET_W  = 32
) (
  input  logic              wb_in_clk,
  input  logic              wb_in_reset_n,
  input  logic              wb_in_valid,
  output logic              wb_out_ready,
  input  logic              wb_in_flush,
  input  logic [31:0]       wb_in_IR,
  input  logic [DATA_W-1:0] wb_in_alu_result,
  input  logic [DATA_W-1:0] wb_in_pc_plus4,
  input  logic [DATA_W-1:0] wb_in_mem_rdata,
  input  logic              wb_in_mem_ready,
  output logic              wb_out_w_en,
  output logic [4:0]        wb_out_rd,
  output logic [DATA_W-1:0] wb_out_data,
  output logic [31:0]       wb_out_IR_W,
  output logic              wb_out_addr_err,
  output logic [RET_W-1:0]  wb_out_retired
);

  wb_state_t         state_q;
  logic              accept;
  logic [5:0]        in_op;
  logic              dec_writes;
  logic [4:0]        dec_dest;
  logic [DATA_W-1:0] dec_data;

  logic [31:0]       ir_p0;
  logic [1:0]        off_p0;
  logic [DATA_W-1:0] ld_data;
  logic              ld_misaligned;

  logic              w_en_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] data_p1;
  logic [31:0]       ir_p1;
  logic              addr_err_p1;
  logic [RET_W-1:0]  retired_q;

  assign wb_out_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept       = wb_in_valid && wb_out_ready;
  assign in_op        = wb_in_IR[31:26];

  // Destination/data decode for instructions that complete without memory.
  always_comb begin
    dec_writes = 1'b0;
    dec_dest   = wb_in_IR[15:11];
    dec_data   = wb_in_alu_result;
    if (in_op == OP_RTYPE) begin
      dec_writes = (wb_in_IR[5:0] != FUNCT_JR);
    end else if (is_imm_alu(in_op)) begin
      dec_writes = 1'b1;
      dec_dest   = wb_in_IR[20:16];
    end else if (in_op == OP_JAL) begin
      dec_writes = 1'b1;
      dec_dest   = REG_RA;
      dec_data   = wb_in_pc_plus4 + DATA_W'(4);
    end
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .op         (ir_p0[31:26]),
    .off        (off_p0),
    .rdata      (wb_in_mem_rdata),
    .data       (ld_data),
    .misaligned (ld_misaligned)
  );

  // p0: instruction held while the load is outstanding
  always_ff @(posedge wb_in_clk) begin
    if (accept && !wb_in_flush) begin
      ir_p0  <= wb_in_IR;
      off_p0 <= wb_in_alu_result[1:0];
    end
  end

  // p1: registered write port, live only in the WRITE cycle
  always_ff @(posedge wb_in_clk or negedge wb_in_reset_n) begin
    if (!wb_in_reset_n) begin
      state_q     <= IDLE;
      w_en_p1     <= 1'b0;
      rd_p1       <= '0;
      data_p1     <= '0;
      ir_p1       <= '0;
      addr_err_p1 <= 1'b0;
      retired_q   <= '0;
    end else begin
      w_en_p1     <= 1'b0;
      addr_err_p1 <= 1'b0;
      if (wb_in_flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, WRITE: begin
            if (accept && is_load(in_op)) begin
              state_q <= WAIT_MEM;
            end else if (accept) begin
              state_q   <= WRITE;
              w_en_p1   <= dec_writes && (dec_dest != 5'd0);
              rd_p1     <= dec_dest;
              data_p1   <= dec_data;
              ir_p1     <= wb_in_IR;
              retired_q <= retired_q + RET_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end
          WAIT_MEM: begin
            if (wb_in_mem_ready) begin
              state_q     <= WRITE;
              w_en_p1     <= !ld_misaligned && (ir_p0[20:16] != 5'd0);
              addr_err_p1 <= ld_misaligned;
              rd_p1       <= ir_p0[20:16];
              data_p1     <= ld_data;
              ir_p1       <= ir_p0;
              retired_q   <= retired_q + RET_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wb_out_w_en     = w_en_p1;
  assign wb_out_rd       = rd_p1;
  assign wb_out_data     = data_p1;
  assign wb_out_IR_W     = ir_p1;
  assign wb_out_addr_err = addr_err_p1;
  assign wb_out_retired  = retired_q;

endmodule

// File: tb/tb_estagio_writeback.sv
// Directed bench for estagio_writeback with hand-computed expectations.
module tb_estagio_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [31:0] ir;
  logic [31:0] alu;
  logic [31:0] pc4;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [31:0] ir_w;
  logic        addr_err;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  estagio_writeback #(.DATA_W(32), .RET_W(32)) dut (
    .wb_in_clk        (clk),
    .wb_in_reset_n    (reset_n),
    .wb_in_valid      (valid),
    .wb_out_ready     (ready),
    .wb_in_flush      (flush),
    .wb_in_IR         (ir),
    .wb_in_alu_result (alu),
    .wb_in_pc_plus4   (pc4),
    .wb_in_mem_rdata  (rdata),
    .wb_in_mem_ready  (mem_ready),
    .wb_out_w_en      (w_en),
    .wb_out_rd        (rd),
    .wb_out_data      (data),
    .wb_out_IR_W      (ir_w),
    .wb_out_addr_err  (addr_err),
    .wb_out_retired   (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic exp_wen, input logic [4:0] exp_rd,
                    input logic [31:0] exp_data, input logic [31:0] exp_ret);
    chk({tag, ".w_en"}, 32'(w_en), 32'(exp_wen));
    chk({tag, ".rd"}, 32'(rd), 32'(exp_rd));
    chk({tag, ".data"}, data, exp_data);
    chk({tag, ".retired"}, retired, exp_ret);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; flush = 1'b0; ir = '0; alu = '0;
    pc4 = '0; rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.w_en", 32'(w_en), 32'd0);
    chk("rst.data", data, 32'd0);
    chk("rst.ir_w", ir_w, 32'd0);
    chk("rst.retired", retired, 32'd0);
    reset_n = 1'b1;

    // add $t2 <- alu 7
    valid = 1'b1; ir = 32'h0109_5020; alu = 32'h0000_0007;
    tick(); valid = 1'b0;
    wr("add", 1'b1, 5'd10, 32'h7, 32'd1);
    chk("add.ir_w", ir_w, 32'h0109_5020);
    chk("add.ready", 32'(ready), 32'd1);
    tick();
    chk("add.idle_wen", 32'(w_en), 32'd0);

    // lb rt=9, off=3, data 3 cycles late
    valid = 1'b1; ir = 32'h8009_0003; alu = 32'h0000_1003;
    tick(); valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb.wait_ready", 32'(ready), 32'd0);
      chk("lb.wait_wen", 32'(w_en), 32'd0);
      tick();
    end
    mem_ready = 1'b1; rdata = 32'h1122_3380;
    tick(); mem_ready = 1'b0;
    wr("lb", 1'b1, 5'd9, 32'hFFFF_FF80, 32'd2);
    tick();

    // lhu off=2 then jal back-to-back
    valid = 1'b1; ir = 32'h940B_0002; alu = 32'h0000_2002;
    tick(); valid = 1'b0;
    mem_ready = 1'b1; rdata = 32'hAAAA_8001;
    tick(); mem_ready = 1'b0;
    wr("lhu", 1'b1, 5'd11, 32'h0000_8001, 32'd3);
    valid = 1'b1; ir = 32'h0C10_0004; pc4 = 32'h0040_0010;
    tick(); valid = 1'b0;
    wr("jal", 1'b1, 5'd31, 32'h0040_0014, 32'd4);
    tick();

    // lh off=2 sign-extends the low half
    valid = 1'b1; ir = 32'h8410_0002; alu = 32'h0000_0006;
    tick(); valid = 1'b0;
    mem_ready = 1'b1; rdata = 32'h1234_F00D;
    tick(); mem_ready = 1'b0;
    wr("lh", 1'b1, 5'd16, 32'hFFFF_F00D, 32'd5);
    tick();

    // addi to $zero, then misaligned lw
    valid = 1'b1; ir = 32'h2100_0005; alu = 32'h0000_000D;
    tick();
    chk("addi0.w_en", 32'(w_en), 32'd0);
    chk("addi0.addr_err", 32'(addr_err), 32'd0);
    chk("addi0.retired", retired, 32'd6);
    ir = 32'h8C0C_0000; alu = 32'h1000_0002;
    tick(); valid = 1'b0;
    chk("lwmis.ready", 32'(ready), 32'd0);
    mem_ready = 1'b1; rdata = 32'hDEAD_BEEF;
    tick(); mem_ready = 1'b0;
    chk("lwmis.w_en", 32'(w_en), 32'd0);
    chk("lwmis.addr_err", 32'(addr_err), 32'd1);
    chk("lwmis.retired", retired, 32'd7);
    tick();
    chk("lwmis.err_pulse", 32'(addr_err), 32'd0);

    // flush beats mem_ready in WAIT_MEM
    valid = 1'b1; ir = 32'h900D_0001; alu = 32'h0000_0001;
    tick(); valid = 1'b0;
    flush = 1'b1; mem_ready = 1'b1; rdata = 32'h5566_7788;
    tick(); flush = 1'b0; mem_ready = 1'b0;
    chk("flush.ready", 32'(ready), 32'd1);
    chk("flush.w_en", 32'(w_en), 32'd0);
    chk("flush.retired", retired, 32'd7);
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    chk("flush.no_late_wen", 32'(w_en), 32'd0);
    chk("flush.no_late_ret", retired, 32'd7);

    // async reset while waiting for memory
    valid = 1'b1; ir = 32'h840E_0000; alu = 32'h0;
    tick(); valid = 1'b0;
    chk("arst.pre_ready", 32'(ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.ready", 32'(ready), 32'd1);
    chk("arst.rd", 32'(rd), 32'd0);
    chk("arst.data", data, 32'd0);
    chk("arst.ir_w", ir_w, 32'd0);
    chk("arst.retired", retired, 32'd0);
    #1 reset_n = 1'b1;
    mem_ready = 1'b1; rdata = 32'hFFFF_FFFF;
    tick(); mem_ready = 1'b0;
    chk("arst.dropped", 32'(w_en), 32'd0);

    // back-to-back non-loads with valid held high, including jr (retires, no write)
    valid = 1'b1; ir = 32'h0109_5020; alu = 32'h0000_0001;
    tick();
    wr("b2b0", 1'b1, 5'd10, 32'h1, 32'd1);
    chk("b2b0.ready", 32'(ready), 32'd1);
    ir = 32'h3405_00FF; alu = 32'h0000_00FF;
    tick();
    wr("b2b1", 1'b1, 5'd5, 32'hFF, 32'd2);
    chk("b2b1.ready", 32'(ready), 32'd1);
    ir = 32'h03E0_0008; alu = 32'h0000_0040;
    tick();
    chk("b2b2.w_en", 32'(w_en), 32'd0);
    chk("b2b2.retired", retired, 32'd3);
    ir = 32'h0022_1822; alu = 32'h0000_0011;
    tick(); valid = 1'b0;
    wr("b2b3", 1'b1, 5'd3, 32'h11, 32'd4);
    chk("b2b3.ir_w", ir_w, 32'h0022_1822);
    tick();
    chk("b2b.idle_wen", 32'(w_en), 32'd0);
    chk("b2b.idle_ret", retired, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
